// File: rtl/key_beep_pkg.sv
// Shared types and defaults for the key/beep controller.
// Key grant helper picks the lowest pressing index.
package key_beep_pkg;

  localparam int NUM_KEYS = 4;

  localparam int unsigned DEF_CYC_PER_MS    = 50000;
  localparam int unsigned DEF_LONG_MS       = 1000;
  localparam int unsigned DEF_SHORT_BEEP_MS = 100;
  localparam int unsigned DEF_LONG_BEEP_MS  = 500;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    BEEP,
    WAIT_REL
  } state_t;

  function automatic logic [1:0] low_idx(
    input logic [NUM_KEYS-1:0] v
  );
    low_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) low_idx = i[1:0];
    end
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CYC_PER_MS clocks,
// restartable from zero with a synchronous clear.
module ms_tick_gen #(
  parameter int unsigned CYC_PER_MS = 50000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(CYC_PER_MS) + 1;
  localparam logic [CW-1:0] LAST = CW'(CYC_PER_MS - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/key_beep_ctrl.sv
// Key press classifier (short/long) driving a buzzer beep
// whose length depends on the press type.
import key_beep_pkg::*;

module key_beep_ctrl #(
  parameter int unsigned CYC_PER_MS    = DEF_CYC_PER_MS,
  parameter int unsigned LONG_MS       = DEF_LONG_MS,
  parameter int unsigned SHORT_BEEP_MS = DEF_SHORT_BEEP_MS,
  parameter int unsigned LONG_BEEP_MS  = DEF_LONG_BEEP_MS
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_flag,
  input  logic [NUM_KEYS-1:0] key_value,
  output logic                beep,
  output logic                evt_valid,
  output logic [1:0]          evt_id,
  output logic                evt_long,
  output logic                busy
);

  localparam int unsigned MS_A =
    (LONG_MS > SHORT_BEEP_MS) ? LONG_MS : SHORT_BEEP_MS;
  localparam int unsigned MS_MAX =
    (MS_A > LONG_BEEP_MS) ? MS_A : LONG_BEEP_MS;
  localparam int unsigned MW = $clog2(MS_MAX) + 1;

  localparam logic [MW-1:0] LONG_LAST = MW'(LONG_MS - 1);
  localparam logic [MW-1:0] SB_LAST   = MW'(SHORT_BEEP_MS - 1);
  localparam logic [MW-1:0] LB_LAST   = MW'(LONG_BEEP_MS - 1);
  localparam logic [MW-1:0] MS_SAT    = MW'(MS_MAX);

  state_t              state;
  state_t              next_state;
  logic [1:0]          gnt_id;
  logic                rel_pending;
  logic [MW-1:0]       ms_cnt;
  logic                tick;
  logic                st_chg;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rel;
  logic                gnt_rel;
  logic                long_hit;
  logic                beep_done;
  logic                fire;
  logic                fire_long;

  ms_tick_gen #(
    .CYC_PER_MS(CYC_PER_MS)
  ) u_tick (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .clr    (st_chg),
    .tick   (tick)
  );

  assign busy = (state != IDLE);

  always_comb begin
    press      = key_flag & ~key_value;
    rel        = key_flag & key_value;
    gnt_rel    = rel[gnt_id];
    long_hit   = tick && (ms_cnt == LONG_LAST);
    beep_done  = tick &&
                 (ms_cnt == (evt_long ? LB_LAST : SB_LAST));
    next_state = state;
    fire       = 1'b0;
    fire_long  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|press) next_state = HOLD;
      end
      HOLD: begin
        // release beats the long threshold in the same cycle
        if (gnt_rel) begin
          next_state = BEEP;
          fire       = 1'b1;
        end else if (long_hit) begin
          next_state = BEEP;
          fire       = 1'b1;
          fire_long  = 1'b1;
        end
      end
      BEEP: begin
        if (beep_done) begin
          next_state = (rel_pending && !gnt_rel) ? WAIT_REL : IDLE;
        end
      end
      WAIT_REL: begin
        if (gnt_rel) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    st_chg = (next_state != state);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      beep        <= 1'b0;
      evt_valid   <= 1'b0;
      evt_id      <= '0;
      evt_long    <= 1'b0;
      gnt_id      <= '0;
      rel_pending <= 1'b0;
      ms_cnt      <= '0;
    end else begin
      state     <= next_state;
      beep      <= (next_state == BEEP);
      evt_valid <= fire;
      if (fire) begin
        evt_id   <= gnt_id;
        evt_long <= fire_long;
      end
      if (state == IDLE && |press) begin
        gnt_id <= low_idx(press);
      end
      if (fire) begin
        rel_pending <= fire_long;
      end else if (state != IDLE && gnt_rel) begin
        rel_pending <= 1'b0;
      end
      if (st_chg) begin
        ms_cnt <= '0;
      end else if (tick && ms_cnt != MS_SAT) begin
        ms_cnt <= ms_cnt + MW'(1);
      end
    end
  end

endmodule

// File: doc/key_beep_ctrl.md
KEY_BEEP_CTRL -- requirements
Module: key_beep_ctrl

Interface
REQ-001 SHALL have parameter CYC_PER_MS, default 50000, meaning sys_clk cycles per 1 ms tick.
REQ-002 SHALL have parameter LONG_MS, default 1000, meaning the hold time in ms that classifies a press as long.
REQ-003 SHALL have parameter SHORT_BEEP_MS, default 100, meaning the beep duration in ms for a short press.
REQ-004 SHALL have parameter LONG_BEEP_MS, default 500, meaning the beep duration in ms for a long press.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port key_flag, input, 4 bits: per-key 1-cycle pulse from the debouncer marking a stable key change.
REQ-008 SHALL have port key_value, input, 4 bits: per-key debounced level, 0 = pressed, valid when key_flag is high.
REQ-009 SHALL have port beep, output, 1 bit: buzzer drive, high = sounding.
REQ-010 SHALL have port evt_valid, output, 1 bit: 1-cycle pulse for a classified key event.
REQ-011 SHALL have port evt_id, output, 2 bits: index of the key for the event, held until the next event.
REQ-012 SHALL have port evt_long, output, 1 bit: 1 = long press, 0 = short press, held until the next event.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, HOLD, BEEP and WAIT_REL.
REQ-015 A press event on key i SHALL be key_flag[i]=1 with key_value[i]=0; a release event SHALL be key_flag[i]=1 with key_value[i]=1.
REQ-016 In IDLE, on any press event, SHALL grant the lowest-index pressing key, latch its index and enter HOLD on the next edge; simultaneous presses on other keys SHALL be dropped (no queue).
REQ-017 In IDLE, release events SHALL be ignored.
REQ-018 In HOLD, a release of the granted key before LONG_MS*CYC_PER_MS cycles have elapsed since HOLD entry SHALL, on the next edge, pulse evt_valid with evt_long=0 and enter BEEP with duration SHORT_BEEP_MS.
REQ-019 In HOLD, when exactly LONG_MS*CYC_PER_MS cycles have elapsed with no release, SHALL on the next edge pulse evt_valid with evt_long=1, set rel_pending and enter BEEP with duration LONG_BEEP_MS.
REQ-020 When a release and the long threshold occur in the same cycle, the release SHALL win and the event SHALL be classified short.
REQ-021 beep SHALL equal (state==BEEP), registered, and SHALL be high for exactly duration*CYC_PER_MS cycles.
REQ-022 A release of the granted key during BEEP SHALL clear rel_pending.
REQ-023 At the end of BEEP, SHALL enter WAIT_REL if rel_pending=1, else IDLE.
REQ-024 In WAIT_REL, a release of the granted key SHALL return the FSM to IDLE on the next edge; beep SHALL stay low.
REQ-025 In all states other than IDLE, events on non-granted keys SHALL be ignored, and press events on the granted key SHALL be ignored.
REQ-026 The ms prescaler and ms counter SHALL clear on every state transition, so all durations are cycle-exact from state entry.
REQ-027 Counter widths SHALL be $clog2 of the maximum count plus 1; counters SHALL saturate, never wrap.

Reset
REQ-028 While sys_rst=1, at the next edge: state=IDLE, beep=0, evt_valid=0, evt_id=0, evt_long=0, busy=0, rel_pending=0, and all counters=0.
REQ-029 Reset asserted mid-BEEP or mid-HOLD SHALL drop beep low on the next edge and SHALL emit no event.

Structure
REQ-030 Package key_beep_pkg SHALL hold the state enum typedef, the default parameter constants and NUM_KEYS=4.
REQ-031 Sub-module ms_tick_gen SHALL produce a 1-cycle tick every CYC_PER_MS cycles and SHALL have a synchronous clear input driven on state transitions.

Verification (CYC_PER_MS=10, LONG_MS=5, SHORT_BEEP_MS=2, LONG_BEEP_MS=4)
REQ-032 Press key1, release it 20 cycles later -> evt_valid pulse with evt_id=1 and evt_long=0, then beep high for exactly 20 cycles, then IDLE.
REQ-033 Press key2 and hold for 100 cycles -> evt_long=1 exactly 51 cycles after the press flag, beep high 40 cycles, WAIT_REL until release, then IDLE.
REQ-034 Press flags on keys 3, 1 and 0 in the same cycle -> evt_id=0 granted; the key1 and key3 releases are ignored.
REQ-035 Release of the granted key in the same cycle the 50-cycle threshold is reached -> evt_long=0 and a 20-cycle beep.
REQ-036 sys_rst=1 for 1 cycle at beep cycle 5 -> beep=0 and busy=0 on the next edge, and no further evt_valid.
REQ-037 Release-only flag in IDLE, and a key0 press during BEEP -> no event and no state change.
